// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared rv32i types for the hazard/forwarding control blocks.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

  // Every opcode reads rs1 except the ones whose source is the PC or an immediate.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode inside {op_lui, op_auipc, op_jal});
  endfunction

  // Only branches, stores and reg-reg ALU ops read rs2.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {op_br, op_store, op_reg};
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode fields, memory handshakes,
// load enables, flush controls and perf counters.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0]       ifid_opcode;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic [6:0]       idex_opcode;
  logic [4:0]       idex_rd;
  logic             br_taken;
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_read;
  logic             dmem_write;
  logic             dmem_resp;
  logic             ld_pc;
  logic             ld_ifid;
  logic             ld_idex;
  logic             ld_exmem;
  logic             ld_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline datapath side
  modport master (
    output ifid_opcode, ifid_rs1, ifid_rs2, idex_opcode, idex_rd, br_taken,
           imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    input  ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, flush_ifid, flush_idex,
           stall_cnt, bubble_cnt, flush_cnt
  );

  // Hazard controller side
  modport slave (
    input  ifid_opcode, ifid_rs1, ifid_rs2, idex_opcode, idex_rd, br_taken,
           imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    output ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb, flush_ifid, flush_idex,
           stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hz_perf_counters.sv
// Three free-running wrap-around event counters for stall/bubble/flush statistics.
module hz_perf_counters #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc_i,
  input  logic             bubble_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  // Each counter bumps by one on its strobe and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (stall_inc_i)  stall_q  <= stall_q  + 1'b1;
      if (bubble_inc_i) bubble_q <= bubble_q + 1'b1;
      if (flush_inc_i)  flush_q  <= flush_q  + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
  assign flush_cnt_o  = flush_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: memory-wait freeze,
// load-use bubble and taken-branch squash, plus perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  hz_state_t state_q, state_d;
  logic      imem_done_q, imem_done_d;
  logic      dmem_done_q, dmem_done_d;
  logic      imem_ok, dmem_ok, advance, load_use;
  logic      stall_inc, bubble_inc, flush_inc;
  logic [4:0] ld_vec;
  logic [1:0] fl_vec;

  // A request is satisfied if absent, answered now, or answered earlier while frozen.
  assign imem_ok = !hz.imem_read | hz.imem_resp | imem_done_q;
  assign dmem_ok = !(hz.dmem_read | hz.dmem_write) | hz.dmem_resp | dmem_done_q;
  assign advance = imem_ok & dmem_ok;

  // Load in EX whose rd feeds a source register actually read by the instr in ID.
  assign load_use = (hz.idex_opcode == op_load) && (hz.idex_rd != 5'd0) &&
                    ((uses_rs1(hz.ifid_opcode) && (hz.ifid_rs1 == hz.idex_rd)) ||
                     (uses_rs2(hz.ifid_opcode) && (hz.ifid_rs2 == hz.idex_rd)));

  // State and remembered-response flags; reset discards any early response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  // Next state: freeze while any handshake is outstanding, release on advance.
  always_comb begin
    state_d     = state_q;
    imem_done_d = advance ? 1'b0 : (imem_done_q | (hz.imem_read & hz.imem_resp));
    dmem_done_d = advance ? 1'b0 : (dmem_done_q | ((hz.dmem_read | hz.dmem_write) & hz.dmem_resp));
    case (state_q)
      RUN:      if (!advance) state_d = MEM_WAIT;
      MEM_WAIT: if (advance)  state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Outputs: branch squash beats load-use bubble; a taken branch seen while frozen
  // is still presented by ID/EX and gets flushed on the release cycle.
  always_comb begin
    ld_vec     = 5'b00000;
    fl_vec     = 2'b00;
    stall_inc  = 1'b0;
    bubble_inc = 1'b0;
    flush_inc  = 1'b0;
    if (rst_n) begin
      if (!advance) begin
        stall_inc = 1'b1;
      end else if (hz.br_taken) begin
        ld_vec    = 5'b11111;
        fl_vec    = 2'b11;
        flush_inc = 1'b1;
      end else if (load_use) begin
        ld_vec     = 5'b00111;
        fl_vec     = 2'b01;
        bubble_inc = 1'b1;
      end else begin
        ld_vec = 5'b11111;
      end
    end
  end

  assign {hz.ld_pc, hz.ld_ifid, hz.ld_idex, hz.ld_exmem, hz.ld_memwb} = ld_vec;
  assign {hz.flush_ifid, hz.flush_idex} = fl_vec;

  hz_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc_i  (stall_inc),
    .bubble_inc_i (bubble_inc),
    .flush_inc_i  (flush_inc),
    .stall_cnt_o  (hz.stall_cnt),
    .bubble_cnt_o (hz.bubble_cnt),
    .flush_cnt_o  (hz.flush_cnt)
  );
endmodule
